// File: rtl/gate_tester.sv
// gate_tester: applies all four input vectors to a 2-input gate and compares its output
// against TRUTH_TABLE. Define GATE_TESTER_FAIL_MASK_EN to keep per-vector mismatch flags.
module gate_tester #(
    parameter logic [3:0]  TRUTH_TABLE = 4'b0111,
    parameter int unsigned SETTLE      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam logic [3:0] CntLast = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] drv_q, drv_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic       accept;
    logic       mismatch;

    assign accept   = (state_q == StIdle) && start;
    assign mismatch = (dut_f != TRUTH_TABLE[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CntLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                // Saturate defensively; four vectors can never exceed 4 anyway.
                if (mismatch && (err_q != 3'd7)) begin
                    err_d = err_q + 3'd1;
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = StSettle;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                pass_d  = (err_q == 3'd0);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Gate inputs are registered from next-state so they track vec in the same cycle.
    always_comb begin
        drv_d = 2'b00;
        if ((state_d == StSettle) || (state_d == StSample)) begin
            drv_d = vec_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            drv_q   <= 2'b00;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            drv_q   <= drv_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

`ifdef GATE_TESTER_FAIL_MASK_EN
    logic [3:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (accept) begin
            mask_d = 4'b0000;
        end else if ((state_q == StSample) && mismatch) begin
            mask_d[vec_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 4'b0000;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign fail_mask = mask_q;
`else
    logic unused_accept;

    assign unused_accept = accept;
    assign fail_mask     = 4'b0000;
`endif

    assign dut_a   = drv_q[1];
    assign dut_b   = drv_q[0];
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign pass    = pass_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: default instance with selectable gate models plus a SETTLE=1 instance;
// expected run results are queued at start and compared when done appears.
module tb_gate_tester;

    typedef struct packed {
        logic       pass;
        logic [2:0] err;
        logic [3:0] mask;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    logic       a0, b0, f0, busy0, done0, pass0;
    logic       a1, b1, f1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] mask0, mask1;
    int         mode;
    int         sel;
    int         n_checks;
    int         n_errors;
    exp_t       sb[$];

    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [2:0] o_err;
    logic [3:0] o_mask;

    // Gate models: 0 = NAND (correct), 1 = stuck at 1, 2 = AND.
    assign f0 = (mode == 0) ? ~(a0 & b0) : (mode == 1) ? 1'b1 : (a0 & b0);
    assign f1 = ~(a1 & b1);

    assign o_a    = (sel == 1) ? a1 : a0;
    assign o_b    = (sel == 1) ? b1 : b0;
    assign o_busy = (sel == 1) ? busy1 : busy0;
    assign o_done = (sel == 1) ? done1 : done0;
    assign o_pass = (sel == 1) ? pass1 : pass0;
    assign o_err  = (sel == 1) ? err1 : err0;
    assign o_mask = (sel == 1) ? mask1 : mask0;

    gate_tester u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_a(a0), .dut_b(b0), .dut_f(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_mask(mask0)
    );

    gate_tester #(.TRUTH_TABLE(4'b0111), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(a1), .dut_b(b1), .dut_f(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_mask(mask1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input int m);
        exp_t       e;
        logic [3:0] tt;
        logic [1:0] v;
        logic       f;
        tt = 4'b0111;
        e  = '0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            f = (m == 0) ? ~(v[1] & v[0]) : (m == 1) ? 1'b1 : (v[1] & v[0]);
            if (f != tt[v]) begin
                e.err     = e.err + 3'd1;
                e.mask[v] = 1'b1;
            end
        end
        e.pass = (e.err == 3'd0);
`ifndef GATE_TESTER_FAIL_MASK_EN
        e.mask = 4'b0000;
`endif
        return e;
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 1) start1 = v;
        else start0 = v;
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b want 0", {a0, b0, busy0, done0, pass0, err0, mask0});
        end
        n_checks++;
        if ({a1, b1, busy1, done1, pass1, err1, mask1} !== 12'd0) begin
            n_errors++;
            $display("FAIL reset_outputs1: got %b want 0", {a1, b1, busy1, done1, pass1, err1, mask1});
        end
        #9 rst_n = 1'b1;
    endtask

    task automatic run_one(input string name, input int which, input int m, input int settle);
        int         k;
        int         lat;
        int         want_lat;
        logic [1:0] exp_ab;
        exp_t       e;
        sel  = which;
        mode = (which == 1) ? 0 : m;
        want_lat = 4 * (settle + 1) + 1;
        @(posedge clk); #1;
        sb.push_back(model(mode));
        set_start(which, 1'b1);
        k   = 0;
        lat = 0;
        while (lat == 0 && k < 60) begin
            @(posedge clk); #1;
            k++;
            // Mid-run start pulse must be ignored.
            set_start(which, (which == 0) && (k == 5));
            exp_ab = (k <= 4 * (settle + 1)) ? 2'((k - 1) / (settle + 1)) : 2'b00;
            n_checks++;
            if ({o_a, o_b} !== exp_ab) begin
                n_errors++;
                $display("FAIL %s ab_cycle%0d: got %b want %b", name, k, {o_a, o_b}, exp_ab);
            end
            if (o_done === 1'b1) lat = k;
        end
        n_checks++;
        if (lat != want_lat) begin
            n_errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
        end
        e = sb.pop_front();
        n_checks++;
        if ({o_err, o_mask} !== {e.err, e.mask}) begin
            n_errors++;
            $display("FAIL %s err_mask: got %0d/%b want %0d/%b", name, o_err, o_mask, e.err, e.mask);
        end
        // Start raised during DONE must not launch a new run.
        set_start(which, 1'b1);
        @(posedge clk); #1;
        set_start(which, 1'b0);
        n_checks++;
        if ({o_done, o_busy, o_pass} !== {1'b0, 1'b0, e.pass}) begin
            n_errors++;
            $display("FAIL %s after_done: got done/busy/pass %b want %b",
                     name, {o_done, o_busy, o_pass}, {1'b0, 1'b0, e.pass});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({o_busy, o_pass, o_err, o_mask} !== {1'b0, e.pass, e.err, e.mask}) begin
            n_errors++;
            $display("FAIL %s held: got %b want %b", name, {o_busy, o_pass, o_err, o_mask},
                     {1'b0, e.pass, e.err, e.mask});
        end
    endtask

    task automatic test_reset_mid;
        sel  = 0;
        mode = 2;
        @(posedge clk); #1;
        start0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'd0) begin
            n_errors++;
            $display("FAIL reset_mid_async: got %b want 0", {a0, b0, busy0, done0, pass0, err0, mask0});
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({done0, busy0} !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_mid_idle%0d: got done/busy %b want 00", k, {done0, busy0});
            end
        end
        run_one("reset_mid_rerun", 0, 0, 2);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic want_done;
        logic want_busy;
        sel  = 0;
        mode = 0;
        e    = '0;
        @(posedge clk); #1;
        sb.push_back(model(0));
        sb.push_back(model(0));
        start0 = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            @(posedge clk); #1;
            if (k == 27) start0 = 1'b0;
            want_done = (k == 13) || (k == 27);
            want_busy = !((k == 14) || (k >= 28));
            n_checks++;
            if ({done0, busy0} !== {want_done, want_busy}) begin
                n_errors++;
                $display("FAIL b2b_cycle%0d: got done/busy %b want %b", k, {done0, busy0},
                         {want_done, want_busy});
            end
            if (want_done) begin
                e = sb.pop_front();
                n_checks++;
                if ({err0, mask0} !== {e.err, e.mask}) begin
                    n_errors++;
                    $display("FAIL b2b_result%0d: got %b want %b", k, {err0, mask0}, {e.err, e.mask});
                end
            end
            if (k == 14 || k == 28) begin
                n_checks++;
                if (pass0 !== e.pass) begin
                    n_errors++;
                    $display("FAIL b2b_pass%0d: got %b want %b", k, pass0, e.pass);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        mode     = 0;
        sel      = 0;
        test_reset();
        run_one("nand", 0, 0, 2);
        run_one("stuck1", 0, 1, 2);
        run_one("and", 0, 2, 2);
        run_one("nand_again", 0, 0, 2);
        run_one("settle1", 1, 0, 1);
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
